// File: rtl/axil_regbank_if.sv
// AXI4-Lite bus bundle for axil_regbank: AW/W/B/AR/R channels with master/slave views.
interface axil_regbank_if #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0] awaddr;
   logic              awvalid;
   logic              awready;
   logic [DATA_W-1:0] wdata;
   logic [STRB_W-1:0] wstrb;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [ADDR_W-1:0] araddr;
   logic              arvalid;
   logic              arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axil_regbank.sv
// AXI4-Lite register bank with byte strobes, per-register read-only mask and hardware-fed RO registers.
// Define AXIL_REGBANK_ERR_EN to return SLVERR on decode errors and RO writes (otherwise all OKAY).
module axil_regbank #(
   parameter int unsigned          DATA_W    = 32,
   parameter int unsigned          ADDR_W    = 12,
   parameter int unsigned          NUM_REGS  = 16,
   parameter logic [NUM_REGS-1:0]  RO_MASK   = '0,
   parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   axil_regbank_if.slave                s_axil,
   input  logic [NUM_REGS*DATA_W-1:0]   hw_in,
   output logic [NUM_REGS*DATA_W-1:0]   regs_q
);
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OFF    = $clog2(STRB_W);
   localparam int unsigned IDX_W  = ADDR_W - OFF;

   typedef enum logic {W_COLLECT, W_RESP} w_state_t;

   w_state_t          r_state, w_state_nxt;
   logic              r_aw_held, r_w_held;
   logic [ADDR_W-1:0] r_awaddr;
   logic [DATA_W-1:0] r_wdata;
   logic [STRB_W-1:0] r_wstrb;
   logic              r_bvalid;
   logic [1:0]        r_bresp;
   logic              r_rvalid;
   logic [DATA_W-1:0] r_rdata;
   logic [1:0]        r_rresp;
   logic [DATA_W-1:0] r_regs [NUM_REGS];

   logic              w_awready, w_wready, w_aw_hs, w_w_hs, w_commit, w_ar_hs;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [DATA_W-1:0] w_wr_data;
   logic [STRB_W-1:0] w_wr_strb;
   logic [IDX_W-1:0]  w_wr_idx, w_rd_idx;
   logic              w_wr_err, w_rd_err;
   logic [1:0]        w_bresp, w_rresp;
   logic [DATA_W-1:0] w_rd_data;

   // Write FSM: next state, channel readies and commit strobe
   always_comb begin
      w_state_nxt = r_state;
      w_awready   = 1'b0;
      w_wready    = 1'b0;
      w_aw_hs     = 1'b0;
      w_w_hs      = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         W_COLLECT: begin
            w_awready = !r_aw_held;
            w_wready  = !r_w_held;
            w_aw_hs   = s_axil.awvalid && w_awready;
            w_w_hs    = s_axil.wvalid && w_wready;
            if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) begin
               w_commit    = 1'b1;
               w_state_nxt = W_RESP;
            end
         end
         W_RESP: begin
            if (s_axil.bready) w_state_nxt = W_COLLECT;
         end
         default: w_state_nxt = W_COLLECT;
      endcase
   end

   // A channel completing on the commit edge supplies its payload directly
   assign w_wr_addr = w_aw_hs ? s_axil.awaddr : r_awaddr;
   assign w_wr_data = w_w_hs  ? s_axil.wdata  : r_wdata;
   assign w_wr_strb = w_w_hs  ? s_axil.wstrb  : r_wstrb;
   assign w_wr_idx  = w_wr_addr[ADDR_W-1:OFF];
   assign w_wr_err  = (w_wr_addr[OFF-1:0] != '0) || (32'(w_wr_idx) >= NUM_REGS);

`ifdef AXIL_REGBANK_ERR_EN
   logic w_wr_ro;
   always_comb begin
      w_wr_ro = 1'b0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         if (w_wr_idx == IDX_W'(i)) w_wr_ro = RO_MASK[i];
      end
   end
   assign w_bresp = (w_wr_err || w_wr_ro) ? 2'b10 : 2'b00;
   assign w_rresp = w_rd_err ? 2'b10 : 2'b00;
`else
   assign w_bresp = 2'b00;
   assign w_rresp = 2'b00;
`endif

   assign w_ar_hs  = s_axil.arvalid && s_axil.arready;
   assign w_rd_idx = s_axil.araddr[ADDR_W-1:OFF];
   assign w_rd_err = (s_axil.araddr[OFF-1:0] != '0) || (32'(w_rd_idx) >= NUM_REGS);

   // Read mux: RO slots come from hardware, errors read as zero
   always_comb begin
      w_rd_data = '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         if (!w_rd_err && (w_rd_idx == IDX_W'(i)))
            w_rd_data = RO_MASK[i] ? hw_in[i*DATA_W +: DATA_W] : r_regs[i];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= W_COLLECT;
         r_aw_held <= 1'b0;
         r_w_held  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= 2'b00;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= 2'b00;
         for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= RESET_VAL;
      end else begin
         r_state <= w_state_nxt;
         if (w_aw_hs) begin
            r_aw_held <= 1'b1;
            r_awaddr  <= s_axil.awaddr;
         end
         if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= s_axil.wdata;
            r_wstrb  <= s_axil.wstrb;
         end
         if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_bresp;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
               if (!w_wr_err && !RO_MASK[i] && (w_wr_idx == IDX_W'(i))) begin
                  for (int b = 0; b < int'(STRB_W); b++) begin
                     if (w_wr_strb[b]) r_regs[i][8*b +: 8] <= w_wr_data[8*b +: 8];
                  end
               end
            end
         end
         if ((r_state == W_RESP) && s_axil.bready) begin
            r_bvalid  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
         end
         if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rresp;
         end else if (s_axil.rready) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   assign s_axil.awready = w_awready;
   assign s_axil.wready  = w_wready;
   assign s_axil.bvalid  = r_bvalid;
   assign s_axil.bresp   = r_bresp;
   assign s_axil.arready = !r_rvalid || s_axil.rready;
   assign s_axil.rvalid  = r_rvalid;
   assign s_axil.rdata   = r_rdata;
   assign s_axil.rresp   = r_rresp;

   // RO slices of the contents bus read as zero
   for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_regs_q
      assign regs_q[g*DATA_W +: DATA_W] = RO_MASK[g] ? '0 : r_regs[g];
   end
endmodule

// File: tb/tb_axil_regbank.sv
// Randomised self-checking bench for axil_regbank against an array-based register model.
module tb_axil_regbank;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 12;
   localparam int unsigned NR = 16;
   localparam logic [NR-1:0] RO   = 16'h8000;
   localparam logic [DW-1:0] RVAL = 32'h1234_5678;
`ifdef AXIL_REGBANK_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [NR*DW-1:0]  hw_in;
   logic [NR*DW-1:0]  regs_q;
   int                n_cmp = 0;
   int                n_err = 0;
   logic [DW-1:0]     m_regs [NR];

   axil_regbank_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   axil_regbank #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .RO_MASK(RO), .RESET_VAL(RVAL)) dut (
      .clk(clk), .rst(rst), .s_axil(bus), .hw_in(hw_in), .regs_q(regs_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit m_err(input logic [AW-1:0] a);
      return (a[1:0] != 2'b00) || (a[AW-1:2] >= 10'(NR));
   endfunction

   // Model read: errors read 0, RO reads hardware, RW reads model contents
   function automatic logic [DW-1:0] m_rdata(input logic [AW-1:0] a);
      int idx = int'(a[AW-1:2]);
      if (m_err(a)) return '0;
      if (RO[idx]) return hw_in[idx*DW +: DW];
      return m_regs[idx];
   endfunction

   function automatic logic [1:0] m_rresp(input logic [AW-1:0] a);
      return (ERR_EN && m_err(a)) ? 2'b10 : 2'b00;
   endfunction

   task automatic m_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
      int idx = int'(a[AW-1:2]);
      if (m_err(a) || RO[idx]) begin
         resp = ERR_EN ? 2'b10 : 2'b00;
      end else begin
         resp = 2'b00;
         for (int b = 0; b < 4; b++) if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
      end
   endtask

   task automatic check_regs();
      for (int i = 0; i < int'(NR); i++)
         chk($sformatf("regs_q[%0d]", i), 64'(regs_q[i*DW +: DW]), 64'(RO[i] ? '0 : m_regs[i]));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < int'(NR); i++) m_regs[i] = RVAL;
   endtask

   // One write with independent AW/W delays and a B back-pressure length
   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly);
      bit aw_done = 0, w_done = 0, aw_hs, w_hs;
      int cyc = 0;
      logic [1:0] resp;
      while (!(aw_done && w_done) && cyc < 20) begin
         bus.awvalid = !aw_done && (cyc >= aw_dly);
         bus.awaddr  = a;
         bus.wvalid  = !w_done && (cyc >= w_dly);
         bus.wdata   = d;
         bus.wstrb   = s;
         chk("bvalid_early", 64'(bus.bvalid), 64'(0));
         chk("awready_held", 64'(bus.awready), 64'(!aw_done));
         chk("wready_held", 64'(bus.wready), 64'(!w_done));
         aw_hs = bus.awvalid && bus.awready;
         w_hs  = bus.wvalid && bus.wready;
         @(posedge clk); #1;
         if (aw_hs) aw_done = 1;
         if (w_hs)  w_done = 1;
         cyc++;
      end
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      if (!(aw_done && w_done)) begin
         chk("wr_timeout", 64'(0), 64'(1));
         return;
      end
      m_write(a, d, s, resp);
      chk("bvalid_lat", 64'(bus.bvalid), 64'(1));
      chk("bresp", 64'(bus.bresp), 64'(resp));
      for (int k = 0; k < b_dly; k++) begin
         @(posedge clk); #1;
         chk("bvalid_hold", 64'(bus.bvalid), 64'(1));
         chk("bresp_hold", 64'(bus.bresp), 64'(resp));
         chk("awready_wresp", 64'(bus.awready), 64'(0));
         chk("wready_wresp", 64'(bus.wready), 64'(0));
      end
      bus.bready = 1'b1;
      @(posedge clk); #1;
      bus.bready = 1'b0;
      chk("bvalid_clr", 64'(bus.bvalid), 64'(0));
      chk("awready_back", 64'(bus.awready), 64'(1));
      check_regs();
   endtask

   // One read with an R back-pressure length; hw_in is disturbed while R is held
   task automatic do_read(input logic [AW-1:0] a, input int r_dly);
      logic [DW-1:0] ed;
      logic [1:0]    er;
      bus.arvalid = 1'b1;
      bus.araddr  = a;
      ed = m_rdata(a);
      er = m_rresp(a);
      chk("arready_idle", 64'(bus.arready), 64'(1));
      @(posedge clk); #1;
      bus.arvalid = 1'b0;
      chk("rvalid", 64'(bus.rvalid), 64'(1));
      chk("rdata", 64'(bus.rdata), 64'(ed));
      chk("rresp", 64'(bus.rresp), 64'(er));
      for (int k = 0; k < r_dly; k++) begin
         hw_in[15*DW +: DW] = $urandom;
         @(posedge clk); #1;
         chk("rdata_hold", 64'(bus.rdata), 64'(ed));
         chk("rresp_hold", 64'(bus.rresp), 64'(er));
         chk("arready_full", 64'(bus.arready), 64'(0));
      end
      bus.rready = 1'b1;
      @(posedge clk); #1;
      bus.rready = 1'b0;
      chk("rvalid_clr", 64'(bus.rvalid), 64'(0));
   endtask

   function automatic logic [AW-1:0] rand_addr();
      case ($urandom_range(0, 9))
         6:       return 12'h03C;
         7:       return AW'($urandom_range(16, 1023) * 4);
         8:       return AW'($urandom_range(0, 1023) * 4 + $urandom_range(1, 3));
         default: return AW'($urandom_range(0, 15) * 4);
      endcase
   endfunction

   initial begin
      logic [DW-1:0] old;
      logic [1:0]    resp;
      rst = 1'b1;
      bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0;
      bus.bready = 0; bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
      for (int i = 0; i < int'(NR); i++) hw_in[i*DW +: DW] = $urandom;
      hw_in[15*DW +: DW] = 32'hCAFE_F00D;
      do_reset();
      chk("rst_bvalid", 64'(bus.bvalid), 64'(0));
      chk("rst_rvalid", 64'(bus.rvalid), 64'(0));
      chk("rst_bresp", 64'(bus.bresp), 64'(0));
      chk("rst_rresp", 64'(bus.rresp), 64'(0));
      chk("rst_rdata", 64'(bus.rdata), 64'(0));
      check_regs();

      // Directed: same-cycle AW/W, W-first, B back-pressure, errors, RO access
      do_write(12'h004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
      do_read(12'h004, 0);
      do_write(12'h004, 32'h1122_3344, 4'b0101, 3, 0, 0);
      do_read(12'h004, 2);
      do_write(12'h000, 32'h0BAD_F00D, 4'h0, 2, 1, 0);
      do_write(12'h008, 32'hA5A5_5A5A, 4'hF, 1, 2, 5);
      do_write(12'h040, 32'hFFFF_FFFF, 4'hF, 0, 0, 1);
      do_write(12'h006, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
      do_read(12'h040, 0);
      do_read(12'h006, 1);
      do_write(12'h03C, 32'h5555_5555, 4'hF, 0, 0, 0);
      hw_in[15*DW +: DW] = 32'hCAFE_F00D;
      do_read(12'h03C, 0);

      // Back-to-back reads at full throughput
      bus.rready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.arvalid = 1'b1;
         bus.araddr  = AW'(i * 4);
         chk("b2b_arready", 64'(bus.arready), 64'(1));
         @(posedge clk); #1;
         chk("b2b_rvalid", 64'(bus.rvalid), 64'(1));
         chk("b2b_rdata", 64'(bus.rdata), 64'(m_rdata(AW'(i * 4))));
      end
      bus.arvalid = 1'b0;
      @(posedge clk); #1;
      bus.rready = 1'b0;
      chk("b2b_drain", 64'(bus.rvalid), 64'(0));

      // Read and commit to the same register on one edge returns the old value
      old = m_regs[3];
      bus.awvalid = 1'b1; bus.awaddr = 12'h00C;
      bus.wvalid = 1'b1; bus.wdata = 32'h7777_8888; bus.wstrb = 4'hF;
      bus.arvalid = 1'b1; bus.araddr = 12'h00C;
      @(posedge clk); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      m_write(12'h00C, 32'h7777_8888, 4'hF, resp);
      chk("rw_same_bvalid", 64'(bus.bvalid), 64'(1));
      chk("rw_same_rdata", 64'(bus.rdata), 64'(old));
      bus.bready = 1'b1; bus.rready = 1'b1;
      @(posedge clk); #1;
      bus.bready = 1'b0; bus.rready = 1'b0;
      check_regs();

      // Reset with AW held: held address discarded, no response
      bus.awvalid = 1'b1; bus.awaddr = 12'h008;
      @(posedge clk); #1;
      bus.awvalid = 1'b0;
      do_reset();
      chk("rstmid_bvalid", 64'(bus.bvalid), 64'(0));
      check_regs();
      bus.wvalid = 1'b1; bus.wdata = 32'h0F0F_0F0F; bus.wstrb = 4'b0011;
      @(posedge clk); #1;
      bus.wvalid = 1'b0;
      chk("w_only_bvalid", 64'(bus.bvalid), 64'(0));
      chk("w_only_wready", 64'(bus.wready), 64'(0));
      bus.awvalid = 1'b1; bus.awaddr = 12'h010;
      @(posedge clk); #1;
      bus.awvalid = 1'b0;
      m_write(12'h010, 32'h0F0F_0F0F, 4'b0011, resp);
      chk("aw_late_bvalid", 64'(bus.bvalid), 64'(1));
      bus.bready = 1'b1;
      @(posedge clk); #1;
      bus.bready = 1'b0;
      check_regs();

      // Randomised traffic
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 3) == 0) hw_in[$urandom_range(0, 15)*DW +: DW] = $urandom;
         if ($urandom_range(0, 1) == 0)
            do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
         else
            do_read(rand_addr(), $urandom_range(0, 2));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
